lsu_reg_master: RTL

- Bus initiator that converts core load/store requests (byte/half/word, byte-addressed) into single accesses on the peripheral register bus.
- Register bus signals: wr_en/be/wr_addr/wdata for writes; rd_en/rd_addr in and rdata/rd_rdy back for reads.
- Sits between the core LSU and the peripheral register file(s), e.g. the UART register block.
- Handles byte-lane steering, write byte-enables, read-data extraction, sign/zero extension and misalignment errors.

---
 rtl/xrv_bus_pkg.sv | 31 +++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/lsu_reg_master.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/xrv_bus_pkg.sv
// Shared register-bus definitions: access-size codes, master FSM state codes,
// default read timeout and the request legality check.
package xrv_bus_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WR   = 3'd1;
  localparam state_t ST_RD   = 3'd2;
  localparam state_t ST_WAIT = 3'd3;
  localparam state_t ST_RESP = 3'd4;

  localparam int DEFAULT_TIMEOUT_CYC = 16;

  // True for the illegal size code and for halves/words not naturally aligned.
  function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane replication,
// load data extraction with sign/zero extension. No state.
module lsu_lane_align
  import xrv_bus_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] lane_wdata_o,
  output logic [31:0] ld_data_o
);

  logic [31:0] shifted_s;
  logic        sext_s;

  // Lane selection per access size; the illegal size enables no lanes.
  always_comb begin
    shifted_s    = bus_rdata_i >> {addr_lo_i, 3'b000};
    sext_s       = 1'b0;
    be_o         = 4'b0000;
    lane_wdata_o = st_data_i;
    ld_data_o    = 32'h0000_0000;
    case (size_i)
      SZ_BYTE: begin
        sext_s       = ~unsigned_i & shifted_s[7];
        be_o         = 4'b0001 << addr_lo_i;
        lane_wdata_o = {4{st_data_i[7:0]}};
        ld_data_o    = {{24{sext_s}}, shifted_s[7:0]};
      end
      SZ_HALF: begin
        sext_s       = ~unsigned_i & shifted_s[15];
        be_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata_o = {2{st_data_i[15:0]}};
        ld_data_o    = {{16{sext_s}}, shifted_s[15:0]};
      end
      SZ_WORD: begin
        be_o         = 4'b1111;
        lane_wdata_o = st_data_i;
        ld_data_o    = shifted_s;
      end
      default: begin
        be_o         = 4'b0000;
        lane_wdata_o = st_data_i;
        ld_data_o    = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_reg_master.sv
// Core load/store to peripheral register-bus initiator, one access per request.
// Read timeout is built only when LSU_REG_MASTER_TIMEOUT_EN is defined.
module lsu_reg_master
  import xrv_bus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              wr_en,
  output logic [3:0]        be,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wdata,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rdata,
  input  logic              rd_rdy
);

  if (ADDR_W < 3) begin : g_bad_addr_w
    $error("lsu_reg_master: ADDR_W must be at least 3");
  end
  if ((TIMEOUT_CYC < 2) || (TIMEOUT_CYC > 256)) begin : g_bad_timeout
    $error("lsu_reg_master: TIMEOUT_CYC must be within 2..256");
  end

  state_t            state_q, state_d;
  logic [1:0]        addr_lo_q, size_q;
  logic              uns_q;
  logic              accept_s, bad_req_s, timeout_s;
  logic [1:0]        al_addr_s, al_size_s;
  logic              al_uns_s;
  logic [3:0]        al_be_s;
  logic [31:0]       al_wdata_s, al_rdata_s;

  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              wr_en_q, wr_en_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  assign accept_s  = req_valid & req_ready_q;
  assign bad_req_s = req_is_bad(req_size, req_addr[1:0]);

  // Bus strobes launch straight from IDLE, so the aligner sees the live request there.
  assign al_addr_s = (state_q == ST_IDLE) ? req_addr[1:0] : addr_lo_q;
  assign al_size_s = (state_q == ST_IDLE) ? req_size      : size_q;
  assign al_uns_s  = (state_q == ST_IDLE) ? req_unsigned  : uns_q;

  lsu_lane_align u_align (
    .addr_lo_i   (al_addr_s),
    .size_i      (al_size_s),
    .unsigned_i  (al_uns_s),
    .st_data_i   (req_wdata),
    .bus_rdata_i (rdata),
    .be_o        (al_be_s),
    .lane_wdata_o(al_wdata_s),
    .ld_data_o   (al_rdata_s)
  );

`ifdef LSU_REG_MASTER_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // Wait counter: held at zero outside WAIT, counts WAIT cycles without rd_rdy.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ST_WAIT) begin
      tmo_cnt_d = 8'd0;
    end else if (!rd_rdy) begin
      tmo_cnt_d = tmo_cnt_q + 8'd1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // State, latched request fields and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= ST_IDLE;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      wr_en_q      <= 1'b0;
      be_q         <= 4'b0000;
      wr_addr_q    <= '0;
      wdata_q      <= 32'h0000_0000;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      if (accept_s) begin
        addr_lo_q <= req_addr[1:0];
        size_q    <= req_size;
        uns_q     <= req_unsigned;
      end
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
      wr_en_q      <= wr_en_d;
      be_q         <= be_d;
      wr_addr_q    <= wr_addr_d;
      wdata_q      <= wdata_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
    end
  end

  // Next-state logic; rd_rdy takes priority over an expiring timeout.
  always_comb begin
    state_d   = state_q;
    timeout_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (bad_req_s) begin
          state_d = ST_RESP;
        end else if (req_we) begin
          state_d = ST_WR;
        end else begin
          state_d = ST_RD;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_RD:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (rd_rdy) begin
          state_d = ST_RESP;
`ifdef LSU_REG_MASTER_TIMEOUT_EN
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = ST_RESP;
          timeout_s = 1'b1;
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values, decoded from the state being entered.
  always_comb begin
    req_ready_d  = (state_d == ST_IDLE);
    wr_en_d      = (state_d == ST_WR);
    rd_en_d      = (state_d == ST_RD);
    resp_valid_d = (state_d == ST_WR) || (state_d == ST_RESP);
    resp_err_d   = 1'b0;
    resp_rdata_d = 32'h0000_0000;
    be_d         = be_q;
    wr_addr_d    = wr_addr_q;
    wdata_d      = wdata_q;
    rd_addr_d    = rd_addr_q;
    case (state_d)
      ST_WR: begin
        be_d      = al_be_s;
        wr_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
        wdata_d   = al_wdata_s;
      end
      ST_RD: begin
        rd_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
      end
      ST_RESP: begin
        resp_err_d   = (state_q == ST_IDLE) | timeout_s;
        resp_rdata_d = resp_err_d ? 32'h0000_0000 : al_rdata_s;
      end
      default: begin
        resp_err_d = 1'b0;
      end
    endcase
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign wr_en      = wr_en_q;
  assign be         = be_q;
  assign wr_addr    = wr_addr_q;
  assign wdata      = wdata_q;
  assign rd_en      = rd_en_q;
  assign rd_addr    = rd_addr_q;

endmodule
